// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: the core and an external loader/debug port share one
// single-ported data memory. Grants last one cycle and ties alternate.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_ack,
  output logic [DW-1:0] ext_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, CORE, EXT} state_t;

  state_t state, state_nxt;
  logic   last_ext, last_ext_nxt;  // last grant went to EXT

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last_ext  <= 1'b1;
      ext_rdata <= '0;
    end else begin
      state    <= state_nxt;
      last_ext <= last_ext_nxt;
      if (ext_ack) ext_rdata <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt    = IDLE;
    last_ext_nxt = last_ext;
    if (core_req && ext_req) state_nxt = last_ext ? CORE : EXT;
    else if (core_req)       state_nxt = CORE;
    else if (ext_req)        state_nxt = EXT;
    if (state_nxt == CORE)     last_ext_nxt = 1'b0;
    else if (state_nxt == EXT) last_ext_nxt = 1'b1;
  end

  // Memory side muxes only on registered state, so the idle port never leaks through.
  // Write/ack are also gated by reset so an aborted grant cannot commit.
  always_comb begin
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    ext_ack    = 1'b0;
    core_rdata = '0;
    case (state)
      CORE: begin
        mem_addr   = core_addr;
        mem_wdata  = core_wdata;
        mem_we     = core_we & core_req & reset;
        core_rdata = mem_rdata;
      end
      EXT: begin
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
        mem_we    = ext_we & ext_req & reset;
        ext_ack   = ext_req & reset;
      end
      default: ;
    endcase
  end

  assign core_stall = core_req & (state != CORE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes expected memory accesses into a
// scoreboard queue, a negedge monitor pops and compares each access it observes.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [1:0] K_CW = 2'd0, K_CR = 2'd1, K_EW = 2'd2, K_ER = 2'd3;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic          clk, reset;
  logic          core_req, core_we, core_stall;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          ext_req, ext_we, ext_ack;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata, ext_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [31:0] tmem [256];
  exp_t        sb [$];
  int          total = 0;
  int          bad   = 0;
  int          acks;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data memory: synchronous write, combinational read
  always @(posedge clk) if (mem_we) tmem[mem_addr[7:0]] <= mem_wdata;
  assign mem_rdata = tmem[mem_addr[7:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.kind = k; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  // monitor: classify each observed access and compare with the queue head
  initial begin
    exp_t e;
    logic [1:0]  k;
    logic [31:0] a, d;
    logic        ev;
    forever begin
      @(negedge clk);
      ev = 1'b0;
      if (reset) begin
        if (mem_we) begin
          ev = 1'b1; k = ext_ack ? K_EW : K_CW; a = mem_addr; d = mem_wdata;
        end else if (ext_ack) begin
          ev = 1'b1; k = K_ER; a = mem_addr; d = mem_rdata;
        end else if (core_req && !core_stall && !core_we) begin
          ev = 1'b1; k = K_CR; a = mem_addr; d = core_rdata;
        end
      end
      if (ev) begin
        if (sb.size() == 0) begin
          chk("unexpected_access", {30'd0, k}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("sb_kind", {30'd0, k}, {30'd0, e.kind});
          chk("sb_addr", a, e.addr);
          chk("sb_data", d, e.data);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) tmem[i] = 32'h0;
    reset = 1'b0;
    core_req = 1'b1; core_we = 1'b1; core_addr = '0; core_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    #2;
    chk("rst_stall", {31'd0, core_stall}, 32'd1);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_ext_ack", {31'd0, ext_ack}, 32'd0);
    chk("rst_core_rdata", core_rdata, 32'd0);
    chk("rst_ext_rdata", ext_rdata, 32'd0);
    core_req = 1'b0;
    @(negedge clk); reset = 1'b1;
    tick();

    // core store then load at 0x40
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h40; core_wdata = 32'hDEADBEEF;
    push(K_CW, 32'h40, 32'hDEADBEEF);
    #1 chk("a_idle_stall", {31'd0, core_stall}, 32'd1);
    tick();
    chk("a_core_stall", {31'd0, core_stall}, 32'd0);
    chk("a_mem_we", {31'd0, mem_we}, 32'd1);
    chk("a_mem_addr", mem_addr, 32'h40);
    tick();
    core_we = 1'b0;
    push(K_CR, 32'h40, 32'hDEADBEEF);
    #1 chk("a_load", core_rdata, 32'hDEADBEEF);
    tick();
    core_req = 1'b0;
    #1 chk("a_drop_we", {31'd0, mem_we}, 32'd0);
    tick();

    // tie right after reset: core first, then one ext_ack
    reset = 1'b0; #1 reset = 1'b1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h50; ext_wdata = 32'h11111111;
    push(K_CR, 32'h40, 32'hDEADBEEF);
    push(K_EW, 32'h50, 32'h11111111);
    #1 chk("b_idle_stall", {31'd0, core_stall}, 32'd1);
    chk("b_idle_ack", {31'd0, ext_ack}, 32'd0);
    tick();
    chk("b_c1_stall", {31'd0, core_stall}, 32'd0);
    chk("b_c1_ack", {31'd0, ext_ack}, 32'd0);
    tick();
    core_req = 1'b0;
    #1 chk("b_c2_ack", {31'd0, ext_ack}, 32'd1);
    chk("b_c2_addr", mem_addr, 32'h50);
    tick();
    ext_req = 1'b0;
    #1 chk("b_c3_ack", {31'd0, ext_ack}, 32'd0);
    tick();
    chk("b_c4_ack", {31'd0, ext_ack}, 32'd0);

    // continuous contention: C,E,C,E... for 10 grants
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h60; core_wdata = 32'h0000C0DE;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h40;
    for (int i = 0; i < 5; i++) begin
      push(K_CW, 32'h60, 32'h0000C0DE);
      push(K_ER, 32'h40, 32'hDEADBEEF);
    end
    #1 chk("c_idle_stall", {31'd0, core_stall}, 32'd1);
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("c_stall", {31'd0, core_stall}, i % 2);
      chk("c_ack", {31'd0, ext_ack}, i % 2);
      if (ext_ack) acks++;
    end
    tick();
    core_req = 1'b0; ext_req = 1'b0;
    tick();
    chk("c_ack_count", acks, 32'd5);
    chk("c_ext_rdata", ext_rdata, 32'hDEADBEEF);

    // external load of a preloaded word
    tmem[8'h10] = 32'h12345678;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h10;
    push(K_ER, 32'h10, 32'h12345678);
    #1 chk("d_idle_ack", {31'd0, ext_ack}, 32'd0);
    chk("d_idle_core_rdata", core_rdata, 32'd0);
    tick();
    chk("d_ack", {31'd0, ext_ack}, 32'd1);
    tick();
    ext_req = 1'b0;
    #1 chk("d_no_ack", {31'd0, ext_ack}, 32'd0);
    chk("d_rdata", ext_rdata, 32'h12345678);
    tick();
    chk("d_rdata_held", ext_rdata, 32'h12345678);

    // reset lands in an ext write grant
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h20; ext_wdata = 32'hA5A5A5A5;
    tick();
    chk("f_ack_before", {31'd0, ext_ack}, 32'd1);
    #1 reset = 1'b0; core_req = 1'b1;
    #1 chk("f_mem_we", {31'd0, mem_we}, 32'd0);
    chk("f_ack", {31'd0, ext_ack}, 32'd0);
    chk("f_ext_rdata", ext_rdata, 32'd0);
    chk("f_stall", {31'd0, core_stall}, 32'd1);
    ext_req = 1'b0; core_req = 1'b0;
    tick();
    chk("f_mem_unchanged", tmem[8'h20], 32'd0);
    reset = 1'b1;
    tick();

    // granted core drops its store; pending ext goes next
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h70; core_wdata = 32'hBAD0BAD0;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h74; ext_wdata = 32'h77777777;
    push(K_EW, 32'h74, 32'h77777777);
    tick();
    core_req = 1'b0;
    #1 chk("e_no_we", {31'd0, mem_we}, 32'd0);
    chk("e_no_stall", {31'd0, core_stall}, 32'd0);
    tick();
    chk("e_ack", {31'd0, ext_ack}, 32'd1);
    chk("e_addr", mem_addr, 32'h74);
    tick();
    ext_req = 1'b0;
    tick();
    chk("e_core_nowrite", tmem[8'h70], 32'd0);
    chk("e_ext_write", tmem[8'h74], 32'h77777777);

    tick();
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
